// File: rtl/fft_addr_gen.sv
// Radix-2 in-place FFT butterfly address generator (stage, group, offset).
// Optional: define FFT_AGEN_BITREV_EN to add a bit-reversed LOAD pass.
module fft_addr_gen #(
  parameter int LOG2N = 8,
  parameter int AW    = LOG2N
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stall,
  output logic [AW-1:0] q_addrA,
  output logic [AW-1:0] q_addrB,
  output logic [AW-2:0] q_addrW,
  output logic [3:0]    q_stage,
  output logic          q_valid,
  output logic          q_last,
  output logic          busy,
  output logic          done
);

  localparam int          NI  = 1 << LOG2N;
  localparam logic [AW:0] N   = NI[AW:0];
  localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [3:0]  L4  = 4'(LOG2N);

`ifdef FFT_AGEN_BITREV_EN
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN, S_LOAD} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;
`endif

  state_t        r_state, w_nstate;
  logic [3:0]    r_s, w_ns;
  logic [AW:0]   r_p, r_j, w_np, w_nj;
  logic [AW-1:0] r_a, r_b, w_na, w_nb;
  logic [AW-2:0] r_w, w_nw;
  logic [3:0]    r_stg, w_nstg;
  logic          r_vld, r_lst, r_busy, r_done;
  logic          w_nvld, w_nlst, w_nbusy, w_ndone;
  logic          w_bf;

  logic [3:0]    w_cs;
  logic [AW:0]   w_cp, w_cj, w_half, w_step;
  logic [AW:0]   w_a, w_b, w_tw;
  logic          w_jl, w_pl, w_stl, w_fin;
  logic          w_unused;

`ifdef FFT_AGEN_BITREV_EN
  logic [AW:0]   r_k, w_nk, w_ck;
  logic          w_ld;

  function automatic logic [AW-1:0] f_rev(input logic [AW-1:0] k);
    logic [AW-1:0] r;
    r = '0;
    for (int i = 0; i < LOG2N; i++) r[i] = k[LOG2N-1-i];
    return r;
  endfunction

  assign w_ck = (r_state == S_IDLE) ? '0 : r_k;
`endif

  // The butterfly about to be issued; IDLE starts at stage 1, p=0, j=0.
  assign w_cs   = (r_state == S_IDLE) ? 4'd1 : r_s;
  assign w_cp   = (r_state == S_IDLE) ? '0 : r_p;
  assign w_cj   = (r_state == S_IDLE) ? '0 : r_j;
  assign w_half = ONE << (w_cs - 4'd1);
  assign w_step = ONE << w_cs;
  assign w_jl   = (w_cj == w_half - ONE);
  assign w_pl   = (w_cp == N - w_step);
  assign w_stl  = w_jl & w_pl;
  assign w_fin  = w_stl & (w_cs == L4);
  assign w_a    = w_cp + w_cj;
  assign w_b    = w_a + w_half;
  assign w_tw   = w_cj << (L4 - w_cs);

  assign w_unused = ^{w_a[AW], w_b[AW], w_tw[AW:AW-1]};

  // Next state, next counters and next registered outputs
  always_comb begin
    w_nstate = r_state;
    w_ns     = r_s;
    w_np     = r_p;
    w_nj     = r_j;
    w_na     = r_a;
    w_nb     = r_b;
    w_nw     = r_w;
    w_nstg   = '0;
    w_nvld   = 1'b0;
    w_nlst   = 1'b0;
    w_nbusy  = 1'b0;
    w_ndone  = 1'b0;
    w_bf     = 1'b0;
`ifdef FFT_AGEN_BITREV_EN
    w_nk     = r_k;
    w_ld     = 1'b0;
`endif
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
`ifdef FFT_AGEN_BITREV_EN
          w_ld = 1'b1;
`else
          w_bf = 1'b1;
`endif
        end
      end
      S_RUN: w_bf = 1'b1;
      S_FIN: begin
        w_ndone  = 1'b1;
        w_nstate = S_IDLE;
        w_ns     = '0;
        w_np     = '0;
        w_nj     = '0;
      end
`ifdef FFT_AGEN_BITREV_EN
      S_LOAD: w_ld = 1'b1;
`endif
      default: w_nstate = S_IDLE;
    endcase
`ifdef FFT_AGEN_BITREV_EN
    if (w_ld) begin
      w_na     = f_rev(w_ck[AW-1:0]);
      w_nb     = w_ck[AW-1:0];
      w_nw     = '0;
      w_nvld   = 1'b1;
      w_nbusy  = 1'b1;
      w_nk     = w_ck + ONE;
      w_nstate = S_LOAD;
      if (w_ck == N - ONE) begin
        w_nstate = S_RUN;
        w_nk     = '0;
        w_ns     = 4'd1;
        w_np     = '0;
        w_nj     = '0;
      end
    end
`endif
    if (w_bf) begin
      w_na     = w_a[AW-1:0];
      w_nb     = w_b[AW-1:0];
      w_nw     = w_tw[AW-2:0];
      w_nstg   = w_cs;
      w_nvld   = 1'b1;
      w_nlst   = w_stl;
      w_nbusy  = 1'b1;
      w_nstate = w_fin ? S_FIN : S_RUN;
      w_ns     = w_cs;
      w_np     = w_cp;
      if (w_jl) begin
        w_nj = '0;
        if (w_pl) begin
          w_np = '0;
          w_ns = w_cs + 4'd1;
        end else begin
          w_np = w_cp + w_step;
        end
      end else begin
        w_nj = w_cj + ONE;
      end
    end
  end

  // FSM state register, frozen while stalled
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else if (!stall) r_state <= w_nstate;
  end

  // Counters and registered outputs, frozen while stalled
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s    <= '0;
      r_p    <= '0;
      r_j    <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_w    <= '0;
      r_stg  <= '0;
      r_vld  <= 1'b0;
      r_lst  <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
`ifdef FFT_AGEN_BITREV_EN
      r_k    <= '0;
`endif
    end else if (!stall) begin
      r_s    <= w_ns;
      r_p    <= w_np;
      r_j    <= w_nj;
      r_a    <= w_na;
      r_b    <= w_nb;
      r_w    <= w_nw;
      r_stg  <= w_nstg;
      r_vld  <= w_nvld;
      r_lst  <= w_nlst;
      r_busy <= w_nbusy;
      r_done <= w_ndone;
`ifdef FFT_AGEN_BITREV_EN
      r_k    <= w_nk;
`endif
    end
  end

  assign q_addrA = r_a;
  assign q_addrB = r_b;
  assign q_addrW = r_w;
  assign q_stage = r_stg;
  assign q_valid = r_vld & ~stall;
  assign q_last  = r_lst & ~stall;
  assign busy    = r_busy;
  assign done    = r_done & ~stall;

endmodule

// File: tb/tb_fft_addr_gen.sv
// Randomized self-checking bench for fft_addr_gen at LOG2N = 3, 8 and 2.
// Expected streams come from a loop-nest model of the butterfly schedule.
module tb_fft_addr_gen;

  logic clk = 1'b0;
  logic rst, start, stall;

  always #5 clk = ~clk;

  localparam int NI = 3;
  int lg [NI] = '{3, 8, 2};

  localparam logic [63:0] M_ALL = 64'h0000_07FF_FFFF_FFFF;
  localparam logic [63:0] M_CTL = 64'hFF << 35;
  localparam logic [63:0] M_VL  = 64'h3 << 39;

  logic [2:0] a3, b3;
  logic [1:0] w3;
  logic [7:0] a8, b8;
  logic [6:0] w8;
  logic [1:0] a2, b2;
  logic [0:0] w2;
  logic [3:0] s3, s8, s2;
  logic v3, l3, y3, d3;
  logic v8, l8, y8, d8;
  logic v2, l2, y2, d2;

  fft_addr_gen #(.LOG2N(3)) u3 (
    .clk(clk), .rst(rst), .start(start), .stall(stall),
    .q_addrA(a3), .q_addrB(b3), .q_addrW(w3), .q_stage(s3),
    .q_valid(v3), .q_last(l3), .busy(y3), .done(d3));

  fft_addr_gen #(.LOG2N(8)) u8 (
    .clk(clk), .rst(rst), .start(start), .stall(stall),
    .q_addrA(a8), .q_addrB(b8), .q_addrW(w8), .q_stage(s8),
    .q_valid(v8), .q_last(l8), .busy(y8), .done(d8));

  fft_addr_gen #(.LOG2N(2)) u2 (
    .clk(clk), .rst(rst), .start(start), .stall(stall),
    .q_addrA(a2), .q_addrB(b2), .q_addrW(w2), .q_stage(s2),
    .q_valid(v2), .q_last(l2), .busy(y2), .done(d2));

  function automatic logic [63:0] pk(
    input logic y, input logic d, input logic v, input logic l,
    input logic [3:0] s, input logic [11:0] a, input logic [11:0] b,
    input logic [10:0] w);
    return {21'b0, y, d, v, l, s, a, b, w};
  endfunction

  logic [63:0] obs [NI];

  always_comb begin
    obs[0] = pk(y3, d3, v3, l3, s3, 12'(a3), 12'(b3), 11'(w3));
    obs[1] = pk(y8, d8, v8, l8, s8, 12'(a8), 12'(b8), 11'(w8));
    obs[2] = pk(y2, d2, v2, l2, s2, 12'(a2), 12'(b2), 11'(w2));
  end

  logic [63:0] exp_mem [NI][2048];
  int exp_len [NI];
  int exp_pos [NI];
  bit act [NI];
  int n_vec;
  int n_err;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  function automatic int brev(input int k, input int l);
    int r;
    r = 0;
    for (int i = 0; i < l; i++) r = r * 2 + ((k >> i) & 1);
    return r;
  endfunction

  task automatic build(input int i);
    int l, n, c, h, g;
    logic lst;
    l = lg[i];
    n = 1 << l;
    c = 0;
`ifdef FFT_AGEN_BITREV_EN
    for (int k = 0; k < n; k++) begin
      exp_mem[i][c] = pk(1'b1, 1'b0, 1'b1, 1'b0, 4'd0,
                         12'(brev(k, l)), 12'(k), 11'd0);
      c++;
    end
`endif
    for (int s = 1; s <= l; s++) begin
      h = 1 << (s - 1);
      g = 1 << s;
      for (int p = 0; p < n; p += g) begin
        for (int j = 0; j < h; j++) begin
          lst = (p == n - g) && (j == h - 1);
          exp_mem[i][c] = pk(1'b1, 1'b0, 1'b1, lst, 4'(s),
                             12'(p + j), 12'(p + j + h), 11'(j * (n / g)));
          c++;
        end
      end
    end
    exp_mem[i][c] = pk(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 12'd0, 12'd0, 11'd0);
    c++;
    exp_len[i] = c;
    exp_pos[i] = 0;
    act[i] = 1'b1;
  endtask

  task automatic observe();
    logic [63:0] e, m;
    for (int i = 0; i < NI; i++) begin
      if (stall) begin
        chk($sformatf("L%0d stall", lg[i]), obs[i] & M_VL, 64'd0);
      end else if (act[i]) begin
        e = exp_mem[i][exp_pos[i]];
        m = e[40] ? M_ALL : M_CTL;
        chk($sformatf("L%0d step%0d", lg[i], exp_pos[i]), obs[i] & m, e & m);
        exp_pos[i]++;
        if (exp_pos[i] == exp_len[i]) act[i] = 1'b0;
      end else begin
        chk($sformatf("L%0d idle", lg[i]), obs[i] & M_CTL, 64'd0);
      end
    end
  endtask

  task automatic cyc(input bit st, input bit sl);
    @(negedge clk);
    observe();
    start = st;
    stall = sl;
    if (st && !sl)
      for (int i = 0; i < NI; i++)
        if (!act[i]) build(i);
  endtask

  task automatic do_reset();
    @(negedge clk);
    observe();
    rst = 1'b0;
    start = 1'b0;
    stall = 1'b0;
    for (int i = 0; i < NI; i++) act[i] = 1'b0;
    #1;
    for (int i = 0; i < NI; i++)
      chk($sformatf("L%0d reset", lg[i]), obs[i], 64'd0);
    @(negedge clk);
    observe();
    rst = 1'b1;
  endtask

  function automatic logic [63:0] any_act();
    return {63'd0, act[0] | act[1] | act[2]};
  endfunction

  initial begin
    int off, c, sl_left;
    bit fired;
    n_vec = 0;
    n_err = 0;
    start = 1'b0;
    stall = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < NI; i++) act[i] = 1'b0;
`ifdef FFT_AGEN_BITREV_EN
    off = 256;
`else
    off = 0;
`endif
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < NI; i++)
      chk($sformatf("L%0d por", lg[i]), obs[i], 64'd0);
    rst = 1'b1;

    cyc(1'b1, 1'b0);
    fired = 1'b0;
    sl_left = 0;
    c = 0;
    while ((act[0] || act[1] || act[2]) && c < 4000) begin
      if (!fired && act[1] && exp_pos[1] == off + 100) begin
        fired = 1'b1;
        sl_left = 5;
      end
      cyc(1'b0, sl_left > 0);
      if (sl_left > 0) sl_left--;
      c++;
    end
    chk("drainA", any_act(), 64'd0);

    cyc(1'b1, 1'b0);
    c = 0;
    while (act[0] && exp_pos[0] < off + 7 && c < 1000) begin
      cyc(1'b1, 1'b0);
      c++;
    end
    do_reset();
    cyc(1'b1, 1'b0);

    for (int k = 0; k < 9000; k++) begin
      if ($urandom_range(0, 2999) == 0) do_reset();
      else cyc($urandom_range(0, 99) < 8, $urandom_range(0, 99) < 20);
    end

    c = 0;
    while ((act[0] || act[1] || act[2]) && c < 4000) begin
      cyc(1'b0, 1'b0);
      c++;
    end
    chk("drainC", any_act(), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fft_addr_gen.md
FFT_ADDR_GEN -- requirements
Module: fft_addr_gen

Interface
REQ-001 SHALL have parameter LOG2N, default 8; transform size N = 2^LOG2N; legal range 2..12.
REQ-002 SHALL have parameter AW, default LOG2N; data address width.
REQ-003 SHALL have port clk, input, 1 bit: clock, rising edge active.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port start, input, 1 bit: one-cycle request to begin a full transform schedule.
REQ-006 SHALL have port stall, input, 1 bit: holds all state and outputs while high.
REQ-007 SHALL have port q_addrA, output, AW bits: butterfly upper input address.
REQ-008 SHALL have port q_addrB, output, AW bits: butterfly lower input address.
REQ-009 SHALL have port q_addrW, output, AW-1 bits: twiddle ROM index.
REQ-010 SHALL have port q_stage, output, 4 bits: current stage number, 1..LOG2N (0 when idle).
REQ-011 SHALL have port q_valid, output, 1 bit: address outputs are valid this cycle.
REQ-012 SHALL have port q_last, output, 1 bit: marks the final butterfly of the current stage.
REQ-013 SHALL have port busy, output, 1 bit: schedule in progress.
REQ-014 SHALL have port done, output, 1 bit: one-cycle pulse when the schedule completes.

Function
REQ-015 SHALL implement FSM states IDLE, RUN and FIN (plus LOAD, see REQ-029).
REQ-016 IDLE SHALL move to RUN on start=1; in RUN and FIN, start SHALL be ignored.
REQ-017 In RUN, stage s SHALL step 1..LOG2N, group base p SHALL step 0, 2^s, ... < N, and offset j SHALL step 0..2^(s-1)-1, with j innermost.
REQ-018 Each non-stalled RUN cycle SHALL register q_addrA=p+j, q_addrB=p+j+2^(s-1), q_addrW=j*(N>>s) and q_valid=1.
REQ-019 Exactly N/2 valid outputs SHALL be produced per stage, N/2*LOG2N in total, with no gap cycles between stages.
REQ-020 q_last SHALL be 1 together with q_valid on the final butterfly of each stage (p=N-2^s, j=2^(s-1)-1).
REQ-021 After the final butterfly of stage LOG2N, the FSM SHALL enter FIN for one cycle with done=1 and q_valid=0, then return to IDLE.
REQ-022 Outputs SHALL have one-cycle latency: the first valid address SHALL appear in the cycle after start is sampled.
REQ-023 While stall=1, counters, FSM state and all outputs SHALL hold; q_valid SHALL read 0, and no butterfly SHALL be skipped or repeated.
REQ-024 busy SHALL be 1 in RUN and LOAD and 0 otherwise.
REQ-025 All address arithmetic SHALL be computed at AW+1 bits and truncated to AW bits; no value SHALL exceed N-1.

Reset
REQ-026 On rst=0, the FSM SHALL enter IDLE and all counters SHALL clear.
REQ-027 On rst=0, all outputs SHALL be 0: q_addrA, q_addrB, q_addrW, q_stage, q_valid, q_last, busy, done.
REQ-028 Reset asserted mid-schedule SHALL abort the schedule without a done pulse; a new start SHALL restart from stage 1.

Configuration
REQ-029 With macro FFT_AGEN_BITREV_EN defined, start SHALL first enter LOAD for N cycles, emitting q_addrA=bitrev(k) for k=0..N-1 with q_valid=1, q_stage=0, q_addrB=k and q_addrW=0; LOAD SHALL then enter RUN.
REQ-030 Without FFT_AGEN_BITREV_EN, the LOAD state SHALL NOT exist and start SHALL go directly to RUN.

Verification
REQ-031 LOG2N=3, start pulse -> stage 1 outputs (A,B,W) = (0,1,0) (2,3,0) (4,5,0) (6,7,0); stage 2 = (0,2,0) (1,3,2) (4,6,0) (5,7,2).
REQ-032 LOG2N=3, continuing -> stage 3 = (0,4,0) (1,5,1) (2,6,2) (3,7,3); 12 valid cycles total; q_last on cycles 4, 8 and 12; done pulse on cycle 13.
REQ-033 LOG2N=8, stall high for 5 cycles at butterfly 100 -> outputs frozen, then butterfly 101 follows; 1024 valid cycles in total.
REQ-034 start reasserted during RUN -> no effect; rst=0 at butterfly 7 -> all outputs 0 and no done pulse; next start -> output (0,1,0).
REQ-035 FFT_AGEN_BITREV_EN defined, LOG2N=3 -> LOAD q_addrA sequence 0,4,2,6,1,5,3,7, then RUN begins with (0,1,0).
REQ-036 LOG2N=2 -> outputs (0,1,0) (2,3,0) (0,2,0) (1,3,1), then done.
